// File: rtl/display_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// display_frame_sequencer_if
// Groups the request/blink inputs and the digit-mux / shift-register / external
// chain strobes of the display frame sequencer.
//   Requester -> sequencer : en, update_req, refresh_tick, blink_mask[2:0], blink_phase
//   Sequencer -> display   : digit_sel[2:0], seg_en, sr_load, sr_shift,
//                            ext_clk, ext_latch, busy, frame_done
// modport slave  : the sequencer side
// modport master : the side that issues requests and observes the strobes
// ----------------------------------------------------------------------------
interface display_frame_sequencer_if;
    logic       en;
    logic       update_req;
    logic       refresh_tick;
    logic [2:0] blink_mask;
    logic       blink_phase;
    logic [2:0] digit_sel;
    logic       seg_en;
    logic       sr_load;
    logic       sr_shift;
    logic       ext_clk;
    logic       ext_latch;
    logic       busy;
    logic       frame_done;

    modport slave (
        input  en, update_req, refresh_tick, blink_mask, blink_phase,
        output digit_sel, seg_en, sr_load, sr_shift, ext_clk, ext_latch,
               busy, frame_done
    );

    modport master (
        output en, update_req, refresh_tick, blink_mask, blink_phase,
        input  digit_sel, seg_en, sr_load, sr_shift, ext_clk, ext_latch,
               busy, frame_done
    );
endinterface

// File: rtl/display_frame_sequencer.sv
// ----------------------------------------------------------------------------
// display_frame_sequencer
// Sequences one display frame: for each digit select the BCD digit, parallel
// load the digit shift register, clock its bits out to the external chain,
// and after the last digit latch the chain. Frame requests (time update,
// 1 Hz tick, idle keep-alive timer) are arbitrated and requests arriving
// mid-frame collapse into a single pending frame. Blink blanking per digit
// group is applied through seg_en during LOAD.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : display_frame_sequencer_if.slave (requests in, strobes out)
// ----------------------------------------------------------------------------
module display_frame_sequencer #(
    parameter int NUM_DIGITS     = 6,
    parameter int BITS_PER_DIGIT = 8,
    parameter int REFRESH_DIV    = 4096
) (
    input  logic                        clk,
    input  logic                        reset_n,
    display_frame_sequencer_if.slave    bus
);
    localparam int DIG_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int BIT_W = $clog2(BITS_PER_DIGIT);
    localparam int KA_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(BITS_PER_DIGIT - 1);
    localparam logic [KA_W-1:0]  KA_LAST    = KA_W'(REFRESH_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIG_W-1:0]   r_digit, w_digit_nxt;
    logic [BIT_W-1:0]   r_bit,   w_bit_nxt;
    logic               r_pend,  w_pend_nxt;
    logic [KA_W-1:0]    r_ka;

    logic               w_ka_hit;
    logic               w_req;
    logic [1:0]         w_grp;
    logic               w_blank;

    logic [2:0]         w_digit_sel;
    logic               w_seg_en;
    logic               w_sr_load;
    logic               w_sr_shift;
    logic               w_ext_clk;
    logic               w_ext_latch;
    logic               w_frame_done;

    // Keep-alive counter is only ever non-zero in IDLE, so the hit term
    // cannot fire mid-frame.
    assign w_ka_hit = (r_state == S_IDLE) && (r_ka == KA_LAST);
    assign w_req    = bus.update_req | bus.refresh_tick | w_ka_hit;

    // Two digits per blink group: seconds, minutes, hours.
    assign w_grp = 2'(r_digit >> 1);

    always_comb begin
        case (w_grp)
            2'd0:    w_blank = bus.blink_mask[0];
            2'd1:    w_blank = bus.blink_mask[1];
            default: w_blank = bus.blink_mask[2];
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_digit_nxt  = r_digit;
        w_bit_nxt    = r_bit;
        w_pend_nxt   = r_pend;
        w_digit_sel  = 3'd0;
        w_seg_en     = 1'b0;
        w_sr_load    = 1'b0;
        w_sr_shift   = 1'b0;
        w_ext_clk    = 1'b0;
        w_ext_latch  = 1'b0;
        w_frame_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.en && (w_req || r_pend)) begin
                    w_state_nxt = S_LOAD;
                    w_digit_nxt = '0;
                    w_pend_nxt  = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_req) w_pend_nxt = 1'b1;
                w_sr_load   = 1'b1;
                w_digit_sel = 3'(r_digit);
                w_seg_en    = ~(bus.blink_phase & w_blank);
                w_bit_nxt   = '0;
                w_state_nxt = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (w_req) w_pend_nxt = 1'b1;
                w_digit_sel = 3'(r_digit);
                w_state_nxt = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (w_req) w_pend_nxt = 1'b1;
                w_digit_sel = 3'(r_digit);
                w_ext_clk   = 1'b1;
                w_sr_shift  = 1'b1;
                if (r_bit == LAST_BIT) begin
                    w_bit_nxt = '0;
                    if (r_digit == LAST_DIGIT) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_digit_nxt = r_digit + DIG_W'(1);
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_bit_nxt   = r_bit + BIT_W'(1);
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_LATCH: begin
                // Bit counter is reused to hold the latch pulse for two cycles.
                if (w_req) w_pend_nxt = 1'b1;
                w_ext_latch = 1'b1;
                if (r_bit == BIT_W'(1)) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_bit_nxt   = r_bit + BIT_W'(1);
                end
            end
            S_DONE: begin
                // Pending is consumed here either way: a dropped en discards it.
                w_frame_done = 1'b1;
                w_pend_nxt   = 1'b0;
                w_digit_nxt  = '0;
                if (bus.en && (r_pend || w_req)) w_state_nxt = S_LOAD;
                else                             w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_digit_nxt = '0;
                w_bit_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_digit <= '0;
            r_bit   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_bit   <= w_bit_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Counts IDLE cycles with en=1; holds while en=0, clears outside IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ka <= '0;
        end else if (r_state != S_IDLE || w_state_nxt != S_IDLE) begin
            r_ka <= '0;
        end else if (bus.en) begin
            r_ka <= (r_ka == KA_LAST) ? '0 : r_ka + KA_W'(1);
        end
    end

    assign bus.digit_sel  = w_digit_sel;
    assign bus.seg_en     = w_seg_en;
    assign bus.sr_load    = w_sr_load;
    assign bus.sr_shift   = w_sr_shift;
    assign bus.ext_clk    = w_ext_clk;
    assign bus.ext_latch  = w_ext_latch;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = w_frame_done;

endmodule
